// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe port source: VC encodings, word layout and the
// per-VC pause/continue gate state with its transition function.
package pcie_pkg;

  localparam logic VC0       = 1'b0;
  localparam logic VC1       = 1'b1;
  localparam int   VC_BIT    = 5;
  localparam int   PAYLOAD_W = 5;
  localparam int   WORD_W    = PAYLOAD_W + 1;

  typedef enum logic {
    GATE_RUN  = 1'b0,
    GATE_HOLD = 1'b1
  } gate_e;

  // Pause dominates continue when both arrive together.
  function automatic gate_e gate_next(input gate_e cur, input logic pause, input logic cont);
    gate_e nxt;
    nxt = cur;
    if (pause)     nxt = GATE_HOLD;
    else if (cont) nxt = GATE_RUN;
    return nxt;
  endfunction

endpackage

// File: rtl/pcie_port_src_vc_buf.sv
// Single-VC circular FIFO (module vc_buf). A push into a full buffer is ignored even
// when a pop happens in the same cycle; the caller reports the drop.
module vc_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 5,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/pcie_port_src.sv
// Per-port PCIe source: two VC buffers, pause/continue gates, VC arbiter and output
// register. Define VC1_STRICT_PRIO_EN to give VC1 absolute priority over round-robin.
module pcie_port_src
  import pcie_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                in_valid,
  input  logic                in_vc,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                in_ready_vc0,
  output logic                in_ready_vc1,
  input  logic                pause_vc0,
  input  logic                continue_vc0,
  input  logic                pause_vc1,
  input  logic                continue_vc1,
  output logic                valid_p,
  output logic [WORD_W-1:0]   data_p,
  output logic                idle,
  output logic                drop
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [PAYLOAD_W-1:0] dout0, dout1;
  logic                 full0, full1, empty0, empty1;
  logic [CW-1:0]        count0, count1;
  logic                 push0, push1, pop0, pop1;
  logic                 elig0, elig1, grant_valid, grant_vc;

  gate_e                gate0_q, gate0_d, gate1_q, gate1_d;
  logic                 valid_q, valid_d;
  logic [WORD_W-1:0]    data_q, data_d;
  logic                 drop_q, drop_d;

  vc_buf #(.DEPTH(DEPTH), .W(PAYLOAD_W)) u_buf0 (
    .clk(clk), .rst_n(reset_L), .push(push0), .pop(pop0), .din(in_data),
    .dout(dout0), .full(full0), .empty(empty0), .count(count0)
  );

  vc_buf #(.DEPTH(DEPTH), .W(PAYLOAD_W)) u_buf1 (
    .clk(clk), .rst_n(reset_L), .push(push1), .pop(pop1), .din(in_data),
    .dout(dout1), .full(full1), .empty(empty1), .count(count1)
  );

  assign push0        = in_valid && (in_vc == VC0);
  assign push1        = in_valid && (in_vc == VC1);
  assign in_ready_vc0 = !full0;
  assign in_ready_vc1 = !full1;
  // Live pause input blocks a pop in the very cycle it is seen.
  assign elig0        = !empty0 && (gate0_q == GATE_RUN) && !pause_vc0;
  assign elig1        = !empty1 && (gate1_q == GATE_RUN) && !pause_vc1;
  assign grant_valid  = elig0 || elig1;
  assign pop0         = grant_valid && (grant_vc == VC0);
  assign pop1         = grant_valid && (grant_vc == VC1);

`ifdef VC1_STRICT_PRIO_EN
  assign grant_vc = elig1;
`else
  logic last_grant_q, last_grant_d;

  assign grant_vc     = (elig0 && elig1) ? ~last_grant_q : elig1;
  assign last_grant_d = grant_valid ? grant_vc : last_grant_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) last_grant_q <= VC1;
    else          last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    gate0_d = gate_next(gate0_q, pause_vc0, continue_vc0);
    gate1_d = gate_next(gate1_q, pause_vc1, continue_vc1);
    valid_d = grant_valid;
    data_d  = '0;
    if (grant_valid) data_d = {grant_vc, (grant_vc == VC1) ? dout1 : dout0};
    drop_d  = in_valid && ((in_vc == VC1) ? full1 : full0);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      gate0_q <= GATE_RUN;
      gate1_q <= GATE_RUN;
      valid_q <= 1'b0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      gate0_q <= gate0_d;
      gate1_q <= gate1_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_p = valid_q;
  assign data_p  = data_q;
  assign drop    = drop_q;
  assign idle    = (count0 == '0) && (count1 == '0) && !valid_q;

endmodule

// File: tb/tb_pcie_port_src.sv
// Directed bench for pcie_port_src: reset, latency, arbitration order, pause/continue,
// full-buffer drop and asynchronous reset mid-stream.
module tb_pcie_port_src;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_vc = 1'b0;
  logic [4:0] in_data = '0;
  logic       in_ready_vc0, in_ready_vc1;
  logic       pause_vc0 = 1'b0, continue_vc0 = 1'b0;
  logic       pause_vc1 = 1'b0, continue_vc1 = 1'b0;
  logic       valid_p, idle, drop;
  logic [5:0] data_p;

  int checks = 0;
  int errors = 0;

  pcie_port_src #(.DEPTH(4)) dut (
    .clk(clk), .reset_L(reset_L),
    .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data),
    .in_ready_vc0(in_ready_vc0), .in_ready_vc1(in_ready_vc1),
    .pause_vc0(pause_vc0), .continue_vc0(continue_vc0),
    .pause_vc1(pause_vc1), .continue_vc1(continue_vc1),
    .valid_p(valid_p), .data_p(data_p), .idle(idle), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic vc, input logic [4:0] d);
    in_valid = 1'b1;
    in_vc    = vc;
    in_data  = d;
  endtask

  task automatic pulse_reset();
    reset_L = 1'b0;
    #2;
    reset_L = 1'b1;
  endtask

`ifdef VC1_STRICT_PRIO_EN
  logic [5:0] order_exp [6] = '{6'h24, 6'h25, 6'h26, 6'h01, 6'h02, 6'h03};
`else
  logic [5:0] order_exp [6] = '{6'h01, 6'h24, 6'h02, 6'h25, 6'h03, 6'h26};
`endif

  initial begin
    // Reset state
    #1 reset_L = 1'b0;
    #2;
    chk("rst_valid", 8'(valid_p), 8'h00);
    chk("rst_data",  8'(data_p),  8'h00);
    chk("rst_drop",  8'(drop),    8'h00);
    chk("rst_idle",  8'(idle),    8'h01);
    chk("rst_rdy0",  8'(in_ready_vc0), 8'h01);
    chk("rst_rdy1",  8'(in_ready_vc1), 8'h01);
    cyc();
    reset_L = 1'b1;
    cyc();
    $display("txn reset released");

    // Single word: write at edge N, visible after edge N+1
    wr(1'b0, 5'h0A);
    cyc();
    in_valid = 1'b0;
    chk("s1_lat_valid", 8'(valid_p), 8'h00);
    chk("s1_lat_idle",  8'(idle),    8'h00);
    cyc();
    chk("s1_valid", 8'(valid_p), 8'h01);
    chk("s1_data",  8'(data_p),  8'h0A);
    $display("txn single word data_p=%h", data_p);
    cyc();
    chk("s1_idle",  8'(idle),    8'h01);
    chk("s1_valid_off", 8'(valid_p), 8'h00);

    // Arbitration order from a fresh reset
    pulse_reset();
    pause_vc0 = 1'b1;
    pause_vc1 = 1'b1;
    wr(1'b0, 5'h01); cyc();
    wr(1'b0, 5'h02); cyc();
    wr(1'b0, 5'h03); cyc();
    wr(1'b1, 5'h04); cyc();
    wr(1'b1, 5'h05); cyc();
    wr(1'b1, 5'h06); cyc();
    in_valid = 1'b0;
    chk("s2_held", 8'(valid_p), 8'h00);
    pause_vc0 = 1'b0; pause_vc1 = 1'b0;
    continue_vc0 = 1'b1; continue_vc1 = 1'b1;
    cyc();
    continue_vc0 = 1'b0; continue_vc1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("s2_valid%0d", i), 8'(valid_p), 8'h01);
      chk($sformatf("s2_data%0d", i),  8'(data_p),  8'(order_exp[i]));
      $display("txn arb word %0d data_p=%h", i, data_p);
    end
    cyc();
    chk("s2_idle", 8'(idle), 8'h01);

    // Pause and continue on VC0 with VC1 empty
    pause_vc0 = 1'b1;
    wr(1'b0, 5'h11); cyc();
    wr(1'b0, 5'h12); cyc();
    wr(1'b0, 5'h13); cyc();
    in_valid = 1'b0;
    chk("s3_paused_a", 8'(valid_p), 8'h00);
    cyc();
    chk("s3_paused_b", 8'(valid_p), 8'h00);
    pause_vc0 = 1'b0; continue_vc0 = 1'b1;
    cyc();
    continue_vc0 = 1'b0;
    chk("s3_cont_edge", 8'(valid_p), 8'h00);
    cyc();
    chk("s3_w0", 8'(data_p), 8'h11);
    chk("s3_v0", 8'(valid_p), 8'h01);
    pause_vc0 = 1'b1;
    cyc();
    chk("s3_same_cycle_pause", 8'(valid_p), 8'h00);
    pause_vc0 = 1'b0; continue_vc0 = 1'b1;
    cyc();
    continue_vc0 = 1'b0;
    chk("s3_cont2_edge", 8'(valid_p), 8'h00);
    cyc();
    chk("s3_w1", 8'(data_p), 8'h12);
    cyc();
    chk("s3_w2", 8'(data_p), 8'h13);
    $display("txn pause/continue last data_p=%h", data_p);
    cyc();
    chk("s3_idle", 8'(idle), 8'h01);

    // Full VC1 buffer while paused
    pause_vc1 = 1'b1;
    wr(1'b1, 5'h01); cyc();
    chk("s4_rdy_1", 8'(in_ready_vc1), 8'h01);
    wr(1'b1, 5'h02); cyc();
    wr(1'b1, 5'h03); cyc();
    chk("s4_rdy_3", 8'(in_ready_vc1), 8'h01);
    chk("s4_nodrop", 8'(drop), 8'h00);
    wr(1'b1, 5'h04); cyc();
    chk("s4_rdy_4", 8'(in_ready_vc1), 8'h00);
    chk("s4_rdy0", 8'(in_ready_vc0), 8'h01);
    wr(1'b1, 5'h05); cyc();
    in_valid = 1'b0;
    chk("s4_drop", 8'(drop), 8'h01);
    cyc();
    chk("s4_drop_once", 8'(drop), 8'h00);
    pause_vc1 = 1'b0; continue_vc1 = 1'b1;
    cyc();
    continue_vc1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("s4_data%0d", i), 8'(data_p), 8'(6'h21 + i));
      $display("txn full-drain word %0d data_p=%h", i, data_p);
    end
    cyc();
    chk("s4_extra", 8'(valid_p), 8'h00);
    chk("s4_idle", 8'(idle), 8'h01);

    // Pause and continue together leave the gate in HOLD
    wr(1'b1, 5'h07);
    pause_vc1 = 1'b1; continue_vc1 = 1'b1;
    cyc();
    in_valid = 1'b0; pause_vc1 = 1'b0; continue_vc1 = 1'b0;
    cyc();
    chk("s5_hold_a", 8'(valid_p), 8'h00);
    pause_vc1 = 1'b1; continue_vc1 = 1'b1;
    cyc();
    pause_vc1 = 1'b0; continue_vc1 = 1'b0;
    cyc();
    chk("s5_hold_b", 8'(valid_p), 8'h00);
    continue_vc1 = 1'b1;
    cyc();
    continue_vc1 = 1'b0;
    cyc();
    chk("s5_release", 8'(data_p), 8'h27);
    $display("txn pause+continue release data_p=%h", data_p);
    cyc();

    // Asynchronous reset with both VCs holding data
    pause_vc1 = 1'b1;
    wr(1'b1, 5'h08); cyc();
    wr(1'b1, 5'h09); cyc();
    wr(1'b0, 5'h0A); cyc();
    wr(1'b0, 5'h0B); cyc();
    chk("s6_pre_valid", 8'(valid_p), 8'h01);
    chk("s6_pre_idle",  8'(idle),    8'h00);
    in_valid = 1'b0;
    pause_vc1 = 1'b0;
    reset_L = 1'b0;
    #1;
    chk("s6_valid", 8'(valid_p), 8'h00);
    chk("s6_data",  8'(data_p),  8'h00);
    chk("s6_idle",  8'(idle),    8'h01);
    chk("s6_rdy1",  8'(in_ready_vc1), 8'h01);
    #2 reset_L = 1'b1;
    cyc();
    cyc();
    chk("s6_post_valid", 8'(valid_p), 8'h00);
    chk("s6_post_idle",  8'(idle),    8'h01);
    $display("txn async reset mid-stream idle=%0d", idle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
